// File: rtl/coleta_votos_pkg.sv
// Shared types and constants for the ballot collector.
package coleta_votos_pkg;

    localparam int CNT_W      = 4;
    localparam int MAX_VOTERS = 15;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        CLOSING,
        RESULT
    } estado_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/contador_uns.sv
// Parameterised popcount of a voter bit vector.
module contador_uns
    import coleta_votos_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0]     bits_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/coleta_votos.sv
// Ballot collector: opens a session, takes one vote per voter, freezes V/tallies on close.
// Optional auto-close after TIMEOUT OPEN cycles when COLETA_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no session since reset
// OPEN    | accepting votes
// CLOSING | one cycle, majority/tie registered from final counts
// RESULT  | results frozen until next start
module coleta_votos
    import coleta_votos_pkg::*;
#(
    parameter int NUM_VOTERS = 3,
    parameter int ID_W       = $clog2(NUM_VOTERS),
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  close,
    input  logic                  vote_valid,
    input  logic [ID_W-1:0]       vote_id,
    input  logic                  vote_yes,
    output logic                  vote_ready,
    output logic                  vote_err,
    output logic [NUM_VOTERS-1:0] V,
    output logic [NUM_VOTERS-1:0] voted,
    output logic [CNT_W-1:0]      yes_count,
    output logic [CNT_W-1:0]      no_count,
    output logic                  majority,
    output logic                  tie,
    output logic                  done,
    output logic                  busy
);

    if (NUM_VOTERS < 2 || NUM_VOTERS > MAX_VOTERS || TIMEOUT < 2) begin : g_param_err
        $error("coleta_votos: parameter out of range");
    end

    estado_t               state_q, state_d;
    logic [NUM_VOTERS-1:0] v_q, v_d, voted_q, voted_d, sel;
    logic [CNT_W-1:0]      yes_q, yes_d, no_q, no_d, pop_yes;
    logic                  majority_q, majority_d, tie_q, tie_d;
    logic                  done_q, done_d, err_q, err_d;
    logic                  accept, reject, timeout_hit;

    // Out-of-range ids shift the one-hot select to zero.
    assign sel    = NUM_VOTERS'(1) << vote_id;
    assign accept = (state_q == OPEN) && vote_valid && (|sel) && !(|(voted_q & sel));
    assign reject = (state_q == OPEN) && vote_valid && !accept;

`ifdef COLETA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] tmr_q, tmr_d;

    always_comb begin
        tmr_d = tmr_q;
        if ((state_q == IDLE || state_q == RESULT) && start) begin
            tmr_d = TW'(TIMEOUT - 1);
        end else if (state_q == OPEN && tmr_q != '0) begin
            tmr_d = tmr_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tmr_q <= '0;
        else     tmr_q <= tmr_d;
    end

    assign timeout_hit = (state_q == OPEN) && (tmr_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        voted_d    = voted_q;
        yes_d      = yes_q;
        no_d       = no_q;
        majority_d = majority_q;
        tie_d      = tie_q;
        done_d     = 1'b0;
        err_d      = reject;
        case (state_q)
            IDLE, RESULT: begin
                if (start) begin
                    state_d    = OPEN;
                    v_d        = '0;
                    voted_d    = '0;
                    yes_d      = '0;
                    no_d       = '0;
                    majority_d = 1'b0;
                    tie_d      = 1'b0;
                end
            end
            OPEN: begin
                if (accept) begin
                    voted_d = voted_q | sel;
                    if (vote_yes) begin
                        v_d   = v_q | sel;
                        yes_d = sat_inc(yes_q);
                    end else begin
                        no_d  = sat_inc(no_q);
                    end
                end
                if (close || timeout_hit || (&voted_d)) state_d = CLOSING;
            end
            CLOSING: begin
                majority_d = yes_q > CNT_W'(NUM_VOTERS / 2);
                tie_d      = (yes_q == no_q) && (yes_q != '0);
                done_d     = 1'b1;
                state_d    = RESULT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            v_q        <= '0;
            voted_q    <= '0;
            yes_q      <= '0;
            no_q       <= '0;
            majority_q <= 1'b0;
            tie_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            voted_q    <= voted_d;
            yes_q      <= yes_d;
            no_q       <= no_d;
            majority_q <= majority_d;
            tie_q      <= tie_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    contador_uns #(.W(NUM_VOTERS)) u_pop_yes (
        .bits_i  (v_q),
        .count_o (pop_yes)
    );

    a_yes_pop : assert property (@(posedge clk) disable iff (rst) pop_yes == yes_q);

    assign vote_ready = (state_q == OPEN);
    assign busy       = (state_q == OPEN) || (state_q == CLOSING);
    assign vote_err   = err_q;
    assign V          = v_q;
    assign voted      = voted_q;
    assign yes_count  = yes_q;
    assign no_count   = no_q;
    assign majority   = majority_q;
    assign tie        = tie_q;
    assign done       = done_q;

endmodule

// File: tb/tb_coleta_votos.sv
// Directed bench for coleta_votos with NUM_VOTERS = 3, TIMEOUT = 5.
module tb_coleta_votos;

    logic       clk, rst, start, close, vote_valid, vote_yes;
    logic [1:0] vote_id;
    logic       vote_ready, vote_err, majority, tie, done, busy;
    logic [2:0] V, voted;
    logic [3:0] yes_count, no_count, pop_v, pop_voted;

    int checks = 0;
    int errors = 0;

    coleta_votos #(.NUM_VOTERS(3), .TIMEOUT(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .close      (close),
        .vote_valid (vote_valid),
        .vote_id    (vote_id),
        .vote_yes   (vote_yes),
        .vote_ready (vote_ready),
        .vote_err   (vote_err),
        .V          (V),
        .voted      (voted),
        .yes_count  (yes_count),
        .no_count   (no_count),
        .majority   (majority),
        .tie        (tie),
        .done       (done),
        .busy       (busy)
    );

    contador_uns #(.W(3)) u_pop_v     (.bits_i(V),     .count_o(pop_v));
    contador_uns #(.W(3)) u_pop_voted (.bits_i(voted), .count_o(pop_voted));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic invariants(input string tag);
        chk({tag, "_sum"}, 32'(yes_count) + 32'(no_count), 32'(pop_voted));
        chk({tag, "_pop"}, 32'(pop_v), 32'(yes_count));
    endtask

    task automatic vote(input int id, input logic y);
        vote_valid = 1'b1;
        vote_id    = id[1:0];
        vote_yes   = y;
        tick();
        vote_valid = 1'b0;
    endtask

    task automatic open_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bit still_open;
        rst = 1'b1; start = 1'b0; close = 1'b0;
        vote_valid = 1'b0; vote_id = 2'd0; vote_yes = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_flags", {vote_ready, vote_err, majority, tie, done, busy}, 6'b0);
        chk("rst_vec",   {V, voted, yes_count, no_count}, 14'b0);

        // Session 1: full ballot, auto-close
        open_session();
        chk("s1_ready", {vote_ready, busy}, 2'b11);
        vote(0, 1'b1);
        vote(1, 1'b0);
        vote(2, 1'b1);
        chk("s1_V", V, 3'b101);
        chk("s1_counts", {yes_count, no_count}, {4'd2, 4'd1});
        chk("s1_closing", {vote_ready, busy, done}, 3'b010);
        invariants("s1");
        tick();
        chk("s1_done", {done, majority, tie, busy}, 4'b1100);
        tick();
        chk("s1_hold", {done, V, yes_count}, {1'b0, 3'b101, 4'd2});

        // Session 2: duplicate and out-of-range rejects, explicit close
        open_session();
        chk("s2_clear", {V, voted, yes_count, no_count, majority}, 15'b0);
        vote(1, 1'b1);
        chk("s2_ok", {vote_err, V}, {1'b0, 3'b010});
        vote(1, 1'b0);
        chk("s2_dup_err", vote_err, 1'b1);
        vote(3, 1'b1);
        chk("s2_range_err", vote_err, 1'b1);
        tick();
        chk("s2_err_gone", vote_err, 1'b0);
        chk("s2_state", {V, voted, yes_count, no_count}, {3'b010, 3'b010, 4'd1, 4'd0});
        invariants("s2");
        close = 1'b1;
        tick();
        close = 1'b0;
        chk("s2_closing", {busy, vote_ready, done}, 3'b100);
        tick();
        chk("s2_done", {done, majority, tie}, 3'b100);

        // Session 3: tie
        open_session();
        vote(0, 1'b1);
        vote(1, 1'b0);
        close = 1'b1;
        tick();
        close = 1'b0;
        tick();
        chk("s3_done", {done, tie, majority}, 3'b110);
        chk("s3_vec", {V, voted}, {3'b001, 3'b011});
        invariants("s3");

        // Session 4: close together with a vote; votes after RESULT ignored
        open_session();
        vote(0, 1'b1);
        vote_valid = 1'b1; vote_id = 2'd2; vote_yes = 1'b1; close = 1'b1;
        tick();
        vote_valid = 1'b0; close = 1'b0;
        chk("s4_vec", {V, voted, busy, vote_ready}, {3'b101, 3'b101, 1'b1, 1'b0});
        tick();
        chk("s4_done", {done, majority}, 2'b11);
        vote(1, 1'b0);
        chk("s4_ignored", {vote_err, V, voted, yes_count, no_count},
            {1'b0, 3'b101, 3'b101, 4'd2, 4'd0});

        // Session 5: reset mid-session
        open_session();
        vote(2, 1'b1);
        chk("s5_vote", V, 3'b100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_rst", {V, voted, yes_count, no_count, majority, tie, done, vote_err, busy, vote_ready}, 20'b0);
        vote(0, 1'b1);
        chk("s5_idle_vote", {vote_err, V, voted, busy}, 8'b0);

        // Session 6: timeout behaviour
        open_session();
        vote(0, 1'b1);
`ifdef COLETA_TIMEOUT_EN
        still_open = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!vote_ready) still_open = 1'b0;
            tick();
        end
        chk("s6_open4", {still_open, vote_ready}, 2'b11);
        tick();
        chk("s6_closing", {busy, vote_ready}, 2'b10);
        tick();
        chk("s6_done", {done, V}, {1'b1, 3'b001});
`else
        still_open = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!vote_ready || !busy) still_open = 1'b0;
        end
        chk("s6_no_timeout", still_open, 1'b1);
        close = 1'b1;
        tick();
        close = 1'b0;
        tick();
        chk("s6_done", {done, V, yes_count}, {1'b1, 3'b001, 4'd1});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
